hazard_control_id: RTL

Stall/halt controller for the ID stage of the 5-stage MIPS pipeline. It detects load-use hazards and hazards on operands of branches resolved in ID. It then freezes the PC and IF/ID register and injects bubbles into ID/EX for the required number of cycles. It also implements a halt request/acknowledge handshake so the debug unit can drain and freeze the pipeline. It sits beside the ID-stage forwarding logic and covers the cases that forwarding from EX/MEM cannot resolve.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_detect_id.sv | 51 +++++
 rtl/hazard_control_id.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/halt controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HAZ  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0] STALL_LOAD_BRANCH = 2'd2;
  localparam logic [1:0] STALL_DEFAULT     = 2'd1;
  localparam logic [4:0] REG_ZERO          = 5'd0;

endpackage

// File: rtl/hazard_detect_id.sv
// Combinational hazard detection for the ID stage: load-use and
// branch-operand hazards that EX/MEM forwarding cannot cover.
module hazard_detect_id
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_reg_write,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] ex_m_rd,
  input  logic             ex_m_mem_read,
  output logic             hazard,
  output logic [1:0]       stall_len
);

  localparam logic [REG_W-1:0] RD_ZERO = REG_W'(REG_ZERO);

  logic [REG_W-1:0] src [2];
  logic [1:0]       src_used;
  logic [1:0]       ex_match;
  logic [1:0]       mem_match;
  logic             h_lu;
  logic             h_bex;
  logic             h_bmem;

  assign src[0]   = if_id_rs;
  assign src[1]   = if_id_rt;
  assign src_used = {id_uses_rt, id_uses_rs};

  // Index 0 is hard-wired zero, so a write to it never creates a dependency.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign ex_match[gi]  = src_used[gi] && (id_ex_rd != RD_ZERO) && (src[gi] == id_ex_rd);
      assign mem_match[gi] = src_used[gi] && (ex_m_rd != RD_ZERO) && (src[gi] == ex_m_rd);
    end
  endgenerate

  assign h_lu   = id_ex_mem_read && (|ex_match);
  assign h_bex  = id_is_branch && id_ex_reg_write && !id_ex_mem_read && (|ex_match);
  assign h_bmem = id_is_branch && ex_m_mem_read && (|mem_match);

  assign hazard    = h_lu || h_bex || h_bmem;
  assign stall_len = (h_lu && id_is_branch) ? STALL_LOAD_BRANCH : STALL_DEFAULT;

endmodule

// File: rtl/hazard_control_id.sv
// ID-stage stall/halt controller: RUN/HAZ/HALT FSM, halt handshake and
// optional stall/halt cycle counters (enabled by HAZARD_PERF_CNT_EN).
module hazard_control_id
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_reg_write,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] ex_m_rd,
  input  logic             ex_m_mem_read,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_flush,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] halt_cycles
);

  state_t     state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic       halt_ack_reg;
  logic       hazard;
  logic [1:0] stall_len;
  logic       stall;

  hazard_detect_id #(.REG_W(REG_W)) u_detect (
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_branch    (id_is_branch),
    .id_ex_rd        (id_ex_rd),
    .id_ex_reg_write (id_ex_reg_write),
    .id_ex_mem_read  (id_ex_mem_read),
    .ex_m_rd         (ex_m_rd),
    .ex_m_mem_read   (ex_m_mem_read),
    .hazard          (hazard),
    .stall_len       (stall_len)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      cnt_reg      <= 2'd0;
      halt_ack_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      halt_ack_reg <= (state_next == HALT);
    end
  end

  // Hazards win over halt; HAZ counts down the remaining forced stall cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (hazard) begin
          if (stall_len == STALL_LOAD_BRANCH) begin
            state_next = HAZ;
            cnt_next   = stall_len - STALL_DEFAULT;
          end
        end else if (halt_req) begin
          state_next = HALT;
        end
      end
      HAZ: begin
        if (cnt_reg <= STALL_DEFAULT) begin
          state_next = RUN;
          cnt_next   = 2'd0;
        end else begin
          cnt_next = cnt_reg - STALL_DEFAULT;
        end
      end
      HALT: begin
        if (!halt_req) state_next = RUN;
      end
      default: begin
        state_next = RUN;
        cnt_next   = 2'd0;
      end
    endcase
  end

  always_comb begin
    stall = 1'b1;
    if (state_reg == RUN) stall = hazard || halt_req;
    if (reset) stall = 1'b1;
    pc_write    = !stall;
    if_id_write = !stall;
    id_ex_flush = stall;
  end

  assign halt_ack = halt_ack_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] halt_cnt_reg;
  logic             stall_inc;
  logic             halt_inc;

  assign stall_inc = (state_reg == HAZ) || ((state_reg == RUN) && hazard);
  assign halt_inc  = (state_reg == HALT);

  // Saturating counters: hold at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      halt_cnt_reg  <= '0;
    end else begin
      if (stall_inc && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (halt_inc && (halt_cnt_reg != '1)) halt_cnt_reg <= halt_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign halt_cycles  = halt_cnt_reg;
`else
  assign stall_cycles = '0;
  assign halt_cycles  = '0;
`endif

endmodule
